// File: rtl/mem_req_arbiter_if.sv
// Fetch, load/store and memory-port signal bundle for mem_req_arbiter.
// slave = the arbiter's view; master = the environment (pipeline stages and memory bridge).
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                inst_req;
  logic [ADDR_W-1:0]   inst_addr;
  logic                inst_addr_ok;
  logic                inst_data_ok;
  logic [DATA_W-1:0]   inst_rdata;

  logic                data_req;
  logic                data_wr;
  logic [DATA_W/8-1:0] data_wstrb;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic                data_addr_ok;
  logic                data_data_ok;
  logic [DATA_W-1:0]   data_rdata;

  logic                mem_req;
  logic                mem_wr;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_addr_ok;
  logic                mem_data_ok;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between fetch and load/store; 0-cycle grant and response routing, in-order.
// A stalled winner is held until accepted; issue stops at MAX_OUTST. ARB_ROUND_ROBIN_EN selects round-robin.
module mem_req_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input logic              clk,
  input logic              reset,
  mem_req_arbiter_if.slave bus
);
  localparam int   CNT_W    = $clog2(MAX_OUTST + 1);
  localparam int   PTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state, state_nxt;
  logic                 hold_src;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [MAX_OUTST-1:0] order_q;
  logic                 winner, winner_req, not_full, req_int, accept, resp, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_full = (count != CNT_W'(MAX_OUTST));
  assign head     = order_q[rd_ptr];
  assign resp     = bus.mem_data_ok && (count != '0);

`ifdef ARB_ROUND_ROBIN_EN
  // Last source accepted; on contention the other one wins. Reset value inst lets data win first.
  logic rr_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= SRC_INST;
    end else if (accept) begin
      rr_last <= winner;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_src <= SRC_INST;
    end else begin
      state <= state_nxt;
      if (state_nxt == HOLD) begin
        hold_src <= winner;
      end
    end
  end

  always_comb begin
    winner     = SRC_INST;
    winner_req = 1'b0;
    if (state == HOLD) begin
      // A locked source that drops its request just releases the lock; nobody issues this cycle.
      winner     = hold_src;
      winner_req = hold_src ? bus.data_req : bus.inst_req;
    end else begin
      winner_req = bus.inst_req | bus.data_req;
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.inst_req && bus.data_req) begin
        winner = ~rr_last;
      end else begin
        winner = bus.data_req;
      end
`else
      winner = bus.data_req;
`endif
    end
    req_int   = winner_req & not_full;
    accept    = req_int & bus.mem_addr_ok;
    state_nxt = (req_int && !bus.mem_addr_ok) ? HOLD : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      order_q <= '0;
    end else begin
      if (accept) begin
        order_q[wr_ptr] <= winner;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (resp) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (accept && !resp) begin
        count <= count + 1'b1;
      end else if (!accept && resp) begin
        count <= count - 1'b1;
      end
    end
  end

  assign bus.mem_req   = req_int;
  assign bus.mem_wr    = req_int && (winner == SRC_DATA) && bus.data_wr;
  assign bus.mem_wstrb = (req_int && winner == SRC_DATA) ? bus.data_wstrb : '0;
  assign bus.mem_wdata = (req_int && winner == SRC_DATA) ? bus.data_wdata : '0;
  assign bus.mem_addr  = !req_int ? '0 : ((winner == SRC_DATA) ? bus.data_addr : bus.inst_addr);

  assign bus.inst_addr_ok = accept && (winner == SRC_INST);
  assign bus.data_addr_ok = accept && (winner == SRC_DATA);

  assign bus.inst_data_ok = resp && (head == SRC_INST);
  assign bus.data_data_ok = resp && (head == SRC_DATA);
  assign bus.inst_rdata   = (resp && head == SRC_INST) ? bus.mem_rdata : '0;
  assign bus.data_rdata   = (resp && head == SRC_DATA) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_mem_req_arbiter;
  localparam int MAX_OUTST = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_req_arbiter #(.MAX_OUTST(MAX_OUTST), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: in-order queue of source ids (0 inst, 1 data), lock on stalled winner.
  bit model_on = 0;
  bit q[$];
  bit lock_v = 0;
  bit lock_src = 0;
  bit rr_last = 0;

  always @(negedge clk) begin
    bit have_w, w, e_req, e_acc, e_resp, hd;
    logic [5:0]  e_ctrl, a_ctrl;
    logic [31:0] e_addr, e_wdata, e_ird, e_drd;
    logic [3:0]  e_strb;
    if (model_on) begin
      if (lock_v) begin
        w      = lock_src;
        have_w = lock_src ? bus.data_req : bus.inst_req;
      end else begin
        have_w = bus.inst_req | bus.data_req;
`ifdef ARB_ROUND_ROBIN_EN
        w = (bus.inst_req && bus.data_req) ? !rr_last : bus.data_req;
`else
        w = bus.data_req;
`endif
      end
      e_req  = have_w && (q.size() < MAX_OUTST);
      e_acc  = e_req && bus.mem_addr_ok;
      e_resp = bus.mem_data_ok && (q.size() > 0);
      hd     = (q.size() > 0) ? q[0] : 1'b0;
      e_ctrl = {e_acc && !w, e_resp && !hd, e_acc && w, e_resp && hd, e_req, e_req && w && bus.data_wr};
      a_ctrl = {bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok, bus.mem_req, bus.mem_wr};
      e_addr  = !e_req ? 32'h0 : (w ? bus.data_addr : bus.inst_addr);
      e_wdata = (e_req && w) ? bus.data_wdata : 32'h0;
      e_strb  = (e_req && w) ? bus.data_wstrb : 4'h0;
      e_ird   = (e_resp && !hd) ? bus.mem_rdata : 32'h0;
      e_drd   = (e_resp && hd) ? bus.mem_rdata : 32'h0;
      chk("model_ctrl", 64'(a_ctrl), 64'(e_ctrl));
      chk("model_mem_addr", 64'(bus.mem_addr), 64'(e_addr));
      chk("model_mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
      chk("model_mem_wstrb", 64'(bus.mem_wstrb), 64'(e_strb));
      chk("model_inst_rdata", 64'(bus.inst_rdata), 64'(e_ird));
      chk("model_data_rdata", 64'(bus.data_rdata), 64'(e_drd));
      if (reset) begin
        q.delete();
        lock_v  = 0;
        rr_last = 0;
      end else begin
        if (e_resp) void'(q.pop_front());
        if (e_acc) begin
          q.push_back(w);
          rr_last = w;
        end
        lock_v   = e_req && !bus.mem_addr_ok;
        lock_src = w;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inst_req    = 0; bus.inst_addr  = '0;
    bus.data_req    = 0; bus.data_wr    = 0; bus.data_wstrb = '0;
    bus.data_addr   = '0; bus.data_wdata = '0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;
  endtask

  initial begin
    bit exp_d [4];
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    model_on = 1;
    @(negedge clk);
    chk("reset_mem_req", 64'(bus.mem_req), 64'h0);
    chk("reset_addr_ok", 64'({bus.inst_addr_ok, bus.data_addr_ok}), 64'h0);
    chk("reset_data_ok", 64'({bus.inst_data_ok, bus.data_data_ok}), 64'h0);
    cyc(); reset = 1'b0;

    // single fetch, response next cycle
    cyc(); bus.inst_req = 1; bus.inst_addr = 32'h1c000000; bus.mem_addr_ok = 1;
    @(negedge clk);
    chk("t1_inst_addr_ok", 64'(bus.inst_addr_ok), 64'h1);
    chk("t1_mem_addr", 64'(bus.mem_addr), 64'h1c000000);
    cyc(); idle(); bus.mem_data_ok = 1; bus.mem_rdata = 32'h02800c04;
    @(negedge clk);
    chk("t1_inst_data_ok", 64'(bus.inst_data_ok), 64'h1);
    chk("t1_inst_rdata", 64'(bus.inst_rdata), 64'h02800c04);
    cyc(); idle(); bus.mem_data_ok = 1; bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("t1_spurious", 64'({bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata}), 64'h0);

    // simultaneous requests: data first, inst next
    cyc(); idle(); bus.inst_req = 1; bus.inst_addr = 32'hB0; bus.data_req = 1; bus.data_addr = 32'hA0;
    bus.mem_addr_ok = 1;
    @(negedge clk);
    chk("t2_data_first", 64'({bus.data_addr_ok, bus.inst_addr_ok}), 64'h2);
    chk("t2_mem_addr", 64'(bus.mem_addr), 64'hA0);
    cyc(); bus.data_req = 0;
    @(negedge clk);
    chk("t2_inst_next", 64'(bus.inst_addr_ok), 64'h1);
    cyc(); idle(); bus.mem_data_ok = 1; bus.mem_rdata = 32'h11;
    @(negedge clk);
    chk("t2_resp_data", 64'({bus.data_data_ok, bus.data_rdata}), 64'h1_00000011);
    cyc(); bus.mem_rdata = 32'h22;
    @(negedge clk);
    chk("t2_resp_inst", 64'({bus.inst_data_ok, bus.inst_rdata}), 64'h1_00000022);

    // both requests held for four accepts
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = '{1, 0, 1, 0};
`else
    exp_d = '{1, 1, 1, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); bus.inst_req = 1; bus.inst_addr = 32'h300 + i; bus.data_req = 1;
      bus.data_addr = 32'h400 + i; bus.mem_addr_ok = 1; bus.mem_data_ok = (i > 0);
      bus.mem_rdata = 32'h50 + i;
      @(negedge clk);
      chk("t2_hold_grant", 64'({bus.data_addr_ok, bus.inst_addr_ok}), exp_d[i] ? 64'h2 : 64'h1);
    end
    cyc(); idle(); bus.mem_data_ok = 1; bus.mem_rdata = 32'h99;
    @(negedge clk);

    // stalled store keeps the port while fetch waits
    cyc(); idle(); bus.data_req = 1; bus.data_wr = 1; bus.data_wstrb = 4'hF;
    bus.data_addr = 32'hC0; bus.data_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t3_mem_wr", 64'({bus.mem_req, bus.mem_wr, bus.mem_wstrb}), 64'h3F);
    for (int i = 0; i < 2; i++) begin
      cyc(); bus.inst_req = 1; bus.inst_addr = 32'hE0;
      @(negedge clk);
      chk("t3_held_addr", 64'(bus.mem_addr), 64'hC0);
      chk("t3_inst_blocked", 64'({bus.inst_addr_ok, bus.mem_wr}), 64'h1);
    end
    cyc(); bus.mem_addr_ok = 1;
    @(negedge clk);
    chk("t3_store_acc", 64'({bus.data_addr_ok, bus.inst_addr_ok}), 64'h2);
    cyc(); bus.data_req = 0; bus.data_wr = 0;
    @(negedge clk);
    chk("t3_inst_acc", 64'(bus.inst_addr_ok), 64'h1);
    cyc();
    @(negedge clk);
    chk("t3_full_block", 64'({bus.mem_req, bus.inst_addr_ok}), 64'h0);
    cyc(); idle(); bus.mem_data_ok = 1; bus.mem_rdata = 32'h5;
    @(negedge clk);
    chk("t3_store_done", 64'({bus.data_data_ok, bus.inst_data_ok}), 64'h2);
    cyc(); bus.mem_rdata = 32'h6;
    @(negedge clk);
    chk("t3_inst_resp", 64'({bus.inst_data_ok, bus.inst_rdata}), 64'h1_00000006);

    // fill to MAX_OUTST, third request blocked, responses in order
    cyc(); idle(); bus.inst_req = 1; bus.inst_addr = 32'h100; bus.mem_addr_ok = 1;
    @(negedge clk);
    chk("t4_i_acc", 64'(bus.inst_addr_ok), 64'h1);
    cyc(); bus.inst_req = 0; bus.data_req = 1; bus.data_addr = 32'h200;
    @(negedge clk);
    chk("t4_d_acc", 64'(bus.data_addr_ok), 64'h1);
    cyc(); bus.inst_req = 1;
    @(negedge clk);
    chk("t4_third_blocked", 64'({bus.mem_req, bus.inst_addr_ok, bus.data_addr_ok}), 64'h0);
    cyc(); idle(); bus.mem_data_ok = 1; bus.mem_rdata = 32'hAAAA0001;
    @(negedge clk);
    chk("t4_resp1", 64'({bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata}), 64'h2_AAAA0001);
    cyc(); bus.mem_rdata = 32'hBBBB0002;
    @(negedge clk);
    chk("t4_resp2", 64'({bus.inst_data_ok, bus.data_data_ok, bus.data_rdata}), 64'h1_BBBB0002);
    chk("t4_inst_rdata0", 64'(bus.inst_rdata), 64'h0);

    // accept and response in the same cycle at count 1
    cyc(); idle(); bus.inst_req = 1; bus.inst_addr = 32'h600; bus.mem_addr_ok = 1;
    @(negedge clk);
    cyc(); idle(); bus.data_req = 1; bus.data_addr = 32'h700; bus.mem_addr_ok = 1;
    bus.mem_data_ok = 1; bus.mem_rdata = 32'h33;
    @(negedge clk);
    chk("t5_pop_inst", 64'({bus.inst_data_ok, bus.inst_rdata}), 64'h1_00000033);
    chk("t5_push_data", 64'(bus.data_addr_ok), 64'h1);
    cyc(); idle(); bus.mem_data_ok = 1; bus.mem_rdata = 32'h44;
    @(negedge clk);
    chk("t5_data_resp", 64'({bus.data_data_ok, bus.data_rdata}), 64'h1_00000044);
    cyc(); bus.mem_rdata = 32'h45;
    @(negedge clk);
    chk("t5_empty", 64'({bus.inst_data_ok, bus.data_data_ok}), 64'h0);

    // locked source withdraws its request, then fetch goes through
    cyc(); idle(); bus.data_req = 1; bus.data_addr = 32'h800;
    @(negedge clk);
    cyc(); idle(); bus.inst_req = 1; bus.inst_addr = 32'h900;
    @(negedge clk);
    cyc(); bus.mem_addr_ok = 1;
    @(negedge clk);
    cyc(); idle(); bus.mem_data_ok = 1; bus.mem_rdata = 32'h77;
    @(negedge clk);

    // reset with two outstanding, then a stray response
    cyc(); idle(); bus.inst_req = 1; bus.mem_addr_ok = 1;
    @(negedge clk);
    cyc(); idle(); bus.data_req = 1; bus.mem_addr_ok = 1;
    @(negedge clk);
    cyc(); idle(); reset = 1'b1;
    @(negedge clk);
    cyc(); reset = 1'b0; bus.mem_data_ok = 1; bus.mem_rdata = 32'hFFFF;
    @(negedge clk);
    chk("t6_dropped", 64'({bus.inst_data_ok, bus.data_data_ok, bus.mem_req}), 64'h0);
    chk("t6_rdata0", 64'({bus.inst_rdata, bus.data_rdata}), 64'h0);
    cyc(); idle();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
